vga_bounce_box: RTL and testbench

- Pixel-generation stage directly downstream of the VGA timing generator.
- Consumes the generator's disp_ena, col and row.
- Renders a solid box that moves one step per frame and bounces off the active-area edges, over a background with a one-pixel border frame.
- Produces registered 12-bit RGB with pixel-valid and once-per-frame status outputs.

---
 rtl/vga_bounce_box.sv | 147 ++++++++++++++
 tb/tb_vga_bounce_box.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_bounce_box.sv
// Pixel stage behind the VGA timing generator: draws a bordered background and a
// square box that moves one step per frame and bounces off the active-area edges.
module vga_bounce_box #(
  parameter int          H_BITS     = 10,
  parameter int          V_BITS     = 8,
  parameter int          H_ACTIVE   = 400,
  parameter int          V_ACTIVE   = 200,
  parameter int          BOX        = 16,
  parameter int          STEP       = 2,
  parameter logic [11:0] BOX_RGB    = 12'hF80,
  parameter logic [11:0] BORDER_RGB = 12'hFFF,
  parameter logic [11:0] BG_RGB     = 12'h008
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_ena,
  input  logic [H_BITS-1:0] col,
  input  logic [V_BITS-1:0] row,
  input  logic              run,
  output logic [11:0]       rgb,
  output logic              pix_valid,
  output logic              frame_tick,
  output logic [H_BITS-1:0] box_x,
  output logic [V_BITS-1:0] box_y,
  output logic [7:0]        bounce_cnt
);

  typedef enum logic {DIR_POS = 1'b0, DIR_NEG = 1'b1} dir_e;

  localparam logic [H_BITS:0]   X_MAX  = (H_BITS+1)'(H_ACTIVE - BOX);
  localparam logic [H_BITS:0]   X_STEP = (H_BITS+1)'(STEP);
  localparam logic [H_BITS:0]   X_BOX  = (H_BITS+1)'(BOX);
  localparam logic [H_BITS-1:0] H_LAST = H_BITS'(H_ACTIVE - 1);
  localparam logic [V_BITS:0]   Y_MAX  = (V_BITS+1)'(V_ACTIVE - BOX);
  localparam logic [V_BITS:0]   Y_STEP = (V_BITS+1)'(STEP);
  localparam logic [V_BITS:0]   Y_BOX  = (V_BITS+1)'(BOX);
  localparam logic [V_BITS-1:0] V_LAST = V_BITS'(V_ACTIVE - 1);

  logic [11:0]       rgb_q, rgb_d;
  logic              pix_valid_q, pix_valid_d;
  logic              frame_tick_q, frame_tick_d;
  logic [H_BITS-1:0] box_x_q, box_x_d;
  logic [V_BITS-1:0] box_y_q, box_y_d;
  dir_e              dx_q, dx_d, dy_q, dy_d;
  logic [7:0]        bounce_cnt_q, bounce_cnt_d;

  logic              in_box, on_border, last_px, flip_x, flip_y;
  logic [H_BITS:0]   x_sum;
  logic [V_BITS:0]   y_sum;

  // Box bounds are compared one bit wider so box_x+BOX never wraps.
  always_comb begin
    in_box    = ({1'b0, col} >= {1'b0, box_x_q}) && ({1'b0, col} < ({1'b0, box_x_q} + X_BOX)) &&
                ({1'b0, row} >= {1'b0, box_y_q}) && ({1'b0, row} < ({1'b0, box_y_q} + Y_BOX));
    on_border = (col == '0) || (col == H_LAST) || (row == '0) || (row == V_LAST);
    last_px   = disp_ena && (col == H_LAST) && (row == V_LAST);
  end

  // NOTE: every output of this block is given a default first so no latch is inferred.
  always_comb begin
    pix_valid_d  = disp_ena;
    frame_tick_d = last_px;
    rgb_d        = '0;
    if (disp_ena) begin
      if (in_box)         rgb_d = BOX_RGB;
      else if (on_border) rgb_d = BORDER_RGB;
      else                rgb_d = BG_RGB;
    end

    x_sum   = {1'b0, box_x_q} + X_STEP;
    y_sum   = {1'b0, box_y_q} + Y_STEP;
    box_x_d = box_x_q;
    box_y_d = box_y_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    flip_x  = 1'b0;
    flip_y  = 1'b0;

    // Moves only on the last visible pixel, so the new position lands in blanking.
    if (last_px && run) begin
      if (dx_q == DIR_POS) begin
        if (x_sum >= X_MAX) begin
          box_x_d = X_MAX[H_BITS-1:0];
          dx_d    = DIR_NEG;
          flip_x  = 1'b1;
        end else begin
          box_x_d = x_sum[H_BITS-1:0];
        end
      end else if ({1'b0, box_x_q} <= X_STEP) begin
        box_x_d = '0;
        dx_d    = DIR_POS;
        flip_x  = 1'b1;
      end else begin
        box_x_d = box_x_q - X_STEP[H_BITS-1:0];
      end

      if (dy_q == DIR_POS) begin
        if (y_sum >= Y_MAX) begin
          box_y_d = Y_MAX[V_BITS-1:0];
          dy_d    = DIR_NEG;
          flip_y  = 1'b1;
        end else begin
          box_y_d = y_sum[V_BITS-1:0];
        end
      end else if ({1'b0, box_y_q} <= Y_STEP) begin
        box_y_d = '0;
        dy_d    = DIR_POS;
        flip_y  = 1'b1;
      end else begin
        box_y_d = box_y_q - Y_STEP[V_BITS-1:0];
      end
    end

    bounce_cnt_d = bounce_cnt_q + 8'(flip_x) + 8'(flip_y);
  end

  // NOTE: state updates use non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_q        <= '0;
      pix_valid_q  <= 1'b0;
      frame_tick_q <= 1'b0;
      box_x_q      <= '0;
      box_y_q      <= '0;
      dx_q         <= DIR_POS;
      dy_q         <= DIR_POS;
      bounce_cnt_q <= '0;
    end else begin
      rgb_q        <= rgb_d;
      pix_valid_q  <= pix_valid_d;
      frame_tick_q <= frame_tick_d;
      box_x_q      <= box_x_d;
      box_y_q      <= box_y_d;
      dx_q         <= dx_d;
      dy_q         <= dy_d;
      bounce_cnt_q <= bounce_cnt_d;
    end
  end

  assign rgb        = rgb_q;
  assign pix_valid  = pix_valid_q;
  assign frame_tick = frame_tick_q;
  assign box_x      = box_x_q;
  assign box_y      = box_y_q;
  assign bounce_cnt = bounce_cnt_q;

endmodule

// File: tb/tb_vga_bounce_box.sv
// Bench for vga_bounce_box: three instances (default, STEP=5, square 200x200 area)
// share one stimulus stream and are compared every cycle against an integer model.
module tb_vga_bounce_box;

  logic       clk = 1'b0;
  logic       rst, disp_ena, run;
  logic [9:0] col;
  logic [7:0] row;

  logic [11:0] rgb_o[3];
  logic        pv_o[3], ft_o[3];
  logic [9:0]  bx_o[3];
  logic [7:0]  by_o[3], bc_o[3];

  always #5 clk = ~clk;

  vga_bounce_box u_a (
    .clk(clk), .rst(rst), .disp_ena(disp_ena), .col(col), .row(row), .run(run),
    .rgb(rgb_o[0]), .pix_valid(pv_o[0]), .frame_tick(ft_o[0]),
    .box_x(bx_o[0]), .box_y(by_o[0]), .bounce_cnt(bc_o[0]));

  vga_bounce_box #(.STEP(5)) u_b (
    .clk(clk), .rst(rst), .disp_ena(disp_ena), .col(col), .row(row), .run(run),
    .rgb(rgb_o[1]), .pix_valid(pv_o[1]), .frame_tick(ft_o[1]),
    .box_x(bx_o[1]), .box_y(by_o[1]), .bounce_cnt(bc_o[1]));

  vga_bounce_box #(.H_ACTIVE(200), .V_ACTIVE(200)) u_c (
    .clk(clk), .rst(rst), .disp_ena(disp_ena), .col(col), .row(row), .run(run),
    .rgb(rgb_o[2]), .pix_valid(pv_o[2]), .frame_tick(ft_o[2]),
    .box_x(bx_o[2]), .box_y(by_o[2]), .bounce_cnt(bc_o[2]));

  typedef struct {
    int          h, v, step;
    int          x, y, dx, dy, cnt;
    logic [11:0] rgb;
    bit          pv, ft;
  } mdl_t;

  mdl_t m[3];
  int   checks = 0;
  int   errors = 0;
  int   ticks[3];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      m[i].x = 0;  m[i].y = 0;  m[i].dx = 1;  m[i].dy = 1;  m[i].cnt = 0;
      m[i].rgb = '0;  m[i].pv = 1'b0;  m[i].ft = 1'b0;
    end
  endfunction

  function automatic logic [11:0] pixel(input int i, input bit de, input int c, input int r);
    if (!de) return 12'h000;
    if (c >= m[i].x && c < m[i].x + 16 && r >= m[i].y && r < m[i].y + 16) return 12'hF80;
    if (c == 0 || c == m[i].h - 1 || r == 0 || r == m[i].v - 1) return 12'hFFF;
    return 12'h008;
  endfunction

  // Move p one step along d; stop at 0 or lim and reverse, counting the bounce.
  function automatic void move(inout int p, inout int d, inout int cnt, input int lim, input int st);
    int n;
    n = p + d * st;
    if (n >= lim)    begin p = lim; d = -1; cnt = (cnt + 1) % 256; end
    else if (n <= 0) begin p = 0;   d = 1;  cnt = (cnt + 1) % 256; end
    else             p = n;
  endfunction

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rgb[%0d]", i),        rgb_o[i], m[i].rgb);
      check($sformatf("pix_valid[%0d]", i),  pv_o[i],  m[i].pv);
      check($sformatf("frame_tick[%0d]", i), ft_o[i],  m[i].ft);
      check($sformatf("box_x[%0d]", i),      bx_o[i],  m[i].x);
      check($sformatf("box_y[%0d]", i),      by_o[i],  m[i].y);
      check($sformatf("bounce_cnt[%0d]", i), bc_o[i],  m[i].cnt);
    end
  endtask

  // Present one pixel for one clock, predict every instance, then compare.
  task automatic step_px(input bit de, input int c, input int r);
    bit last;
    disp_ena = de;
    col      = 10'(c);
    row      = 8'(r);
    for (int i = 0; i < 3; i++) begin
      last     = de && c == m[i].h - 1 && r == m[i].v - 1;
      m[i].pv  = de;
      m[i].ft  = last;
      m[i].rgb = pixel(i, de, c, r);
      if (last && run) begin
        move(m[i].x, m[i].dx, m[i].cnt, m[i].h - 16, m[i].step);
        move(m[i].y, m[i].dy, m[i].cnt, m[i].v - 16, m[i].step);
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) if (ft_o[i] === 1'b1) ticks[i]++;
    check_all();
  endtask

  // A compressed frame: random pixels, then the last pixel of each area size.
  task automatic frame(input bit rn, input int npx);
    int c, r;
    run = rn;
    for (int k = 0; k < npx; k++) begin
      c = $urandom_range(0, 399);
      r = $urandom_range(0, 199);
      if (r == 199 && (c == 199 || c == 399)) r = 198;
      step_px($urandom_range(0, 3) != 0, c, r);
    end
    step_px(1'b1, 199, 199);
    step_px(1'b1, 399, 199);
    step_px(1'b0, 0, 0);
  endtask

  initial begin
    int fx, fy, fc;
    m[0].h = 400; m[0].v = 200; m[0].step = 2;
    m[1].h = 400; m[1].v = 200; m[1].step = 5;
    m[2].h = 200; m[2].v = 200; m[2].step = 2;
    model_reset();
    ticks = '{0, 0, 0};
    rst = 1'b1;  disp_ena = 1'b0;  col = '0;  row = '0;  run = 1'b1;
    #1;
    check_all();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;

    // First frame, directed pixels
    step_px(1'b1, 0, 0);    check("first_box",    rgb_o[0], 12'hF80);
    step_px(1'b1, 16, 0);   check("first_border", rgb_o[0], 12'hFFF);
    step_px(1'b1, 16, 16);  check("first_bg",     rgb_o[0], 12'h008);
    step_px(1'b0, 5, 5);    check("blank_rgb",    rgb_o[0], 12'h000);
                            check("blank_pv",     pv_o[0],  1'b0);
    step_px(1'b1, 199, 199);
    step_px(1'b1, 399, 199);
    check("f1_tick", ft_o[0], 1'b1);
    check("f1_x",    bx_o[0], 2);
    check("f1_y",    by_o[0], 2);
    step_px(1'b0, 0, 0);    check("f1_tick_end", ft_o[0], 1'b0);
    step_px(1'b1, 1, 0);    check("f2_row0",     rgb_o[0], 12'hFFF);
    step_px(1'b1, 5, 1);    check("f2_row1",     rgb_o[0], 12'h008);

    // Free-running frames through the first bounces
    for (int k = 2; k <= 100; k++) begin
      frame(1'b1, $urandom_range(2, 6));
      if (k == 76) begin check("b_x76", bx_o[1], 380); check("b_cnt76", bc_o[1], 2); end
      if (k == 77) begin check("b_x77", bx_o[1], 384); check("b_cnt77", bc_o[1], 3); end
      if (k == 78)       check("b_x78", bx_o[1], 379);
      if (k == 91) begin check("c_x91", bx_o[2], 182); check("c_y91", by_o[2], 182);
                         check("c_cnt91", bc_o[2], 0); end
      if (k == 92) begin check("a_y92", by_o[0], 184); check("a_cnt92", bc_o[0], 1);
                         check("c_x92", bx_o[2], 184); check("c_y92", by_o[2], 184);
                         check("c_cnt92", bc_o[2], 2); end
      if (k == 93) begin check("a_y93", by_o[0], 182); check("a_x93", bx_o[0], 186); end
    end

    // Freeze for three frames
    fx = m[0].x;  fy = m[0].y;  fc = m[0].cnt;
    ticks = '{0, 0, 0};
    for (int k = 0; k < 3; k++) frame(1'b0, $urandom_range(1, 5));
    check("freeze_x",     bx_o[0], fx);
    check("freeze_y",     by_o[0], fy);
    check("freeze_cnt",   bc_o[0], fc);
    check("freeze_ticks", ticks[0], 3);

    // Random run/freeze mix
    for (int k = 0; k < 150; k++) frame($urandom_range(0, 3) != 0, $urandom_range(1, 8));

    // Asynchronous reset in the middle of a line
    run = 1'b1;
    step_px(1'b1, 200, 50);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_rgb", rgb_o[0], 12'h000);
    check("rst_pv",  pv_o[0],  1'b0);
    check_all();
    @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;
    step_px(1'b0, 0, 0);
    step_px(1'b1, 0, 0);   check("post_rst_box", rgb_o[0], 12'hF80);
    step_px(1'b1, 399, 199);
    check("partial_tick", ft_o[0], 1'b1);
    check("partial_x",    bx_o[0], 2);
    step_px(1'b0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
